mem_bus_arbiter: RTL and testbench

Shares the single processor-to-memory bus between three requesters: dcache (loads/stores), icache demand fetch and the instruction prefetcher. It grants one requester per cycle and forwards the memory's accept tag to that requester. It keeps an owner table of outstanding tags, so each completing tag is routed only to the requester that issued it. It sits between the cache/prefetch layer and the memory port, and generates the prefetcher's give_way.

---
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Three-way memory bus arbiter with icache starvation promotion and tag owner table.
// Optional MEM_ARB_PERF_EN adds grant/reject performance counters.
module mem_bus_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 15,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      d_command,
  input  logic [XLEN-1:0] d_addr,
  input  logic [63:0]     d_data,
  input  logic [1:0]      i_command,
  input  logic [XLEN-1:0] i_addr,
  input  logic [1:0]      p_command,
  input  logic [XLEN-1:0] p_addr,
  input  logic [3:0]      mem2proc_response,
  input  logic [3:0]      mem2proc_tag,
  input  logic [63:0]     mem2proc_data,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      d_response,
  output logic [3:0]      i_response,
  output logic [3:0]      p_response,
  output logic [3:0]      d_tag,
  output logic [3:0]      i_tag,
  output logic [3:0]      p_tag,
  output logic [63:0]     mem_data,
  output logic            give_way,
  output logic            tag_err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_d_grants,
  output logic [31:0]     perf_i_grants,
  output logic [31:0]     perf_p_grants,
  output logic [31:0]     perf_rejects
`endif
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2,
    OWN_P    = 2'd3
  } owner_e;

  owner_e          owner_q [NUM_TAGS+1];
  owner_e          owner_d [NUM_TAGS+1];
  logic [SW-1:0]   starve_q, starve_d;
  logic            tag_err_q, tag_err_d;

  owner_e gnt;
  owner_e cpl_own;
  logic   d_act, i_act, p_act;
  logic   acc, rsp_ok, tag_ok, cpl;

  assign d_act = d_command != BUS_NONE;
  assign i_act = i_command != BUS_NONE;
  assign p_act = p_command != BUS_NONE;

  // Promotion lets a starved icache jump ahead of dcache for one grant.
  always_comb begin
    gnt = OWN_NONE;
    if (i_act && starve_q == SLIM) gnt = OWN_I;
    else if (d_act)                gnt = OWN_D;
    else if (i_act)                gnt = OWN_I;
    else if (p_act)                gnt = OWN_P;
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    unique case (gnt)
      OWN_D: begin
        proc2mem_command = d_command;
        proc2mem_addr    = d_addr;
        proc2mem_data    = d_data;
      end
      OWN_I: begin
        proc2mem_command = i_command;
        proc2mem_addr    = i_addr;
      end
      OWN_P: begin
        proc2mem_command = p_command;
        proc2mem_addr    = p_addr;
      end
      default: ;
    endcase
  end

  assign d_response = (gnt == OWN_D) ? mem2proc_response : 4'd0;
  assign i_response = (gnt == OWN_I) ? mem2proc_response : 4'd0;
  assign p_response = (gnt == OWN_P) ? mem2proc_response : 4'd0;
  assign give_way   = p_act && gnt != OWN_P;
  assign mem_data   = mem2proc_data;

  assign acc    = gnt != OWN_NONE && mem2proc_response != 4'd0;
  assign rsp_ok = acc && int'(mem2proc_response) <= NUM_TAGS;
  assign tag_ok = int'(mem2proc_tag) <= NUM_TAGS;
  assign cpl    = mem2proc_tag != 4'd0;

  always_comb begin
    cpl_own = OWN_NONE;
    if (cpl && tag_ok) cpl_own = owner_q[int'(mem2proc_tag)];
  end

  assign d_tag = (cpl_own == OWN_D) ? mem2proc_tag : 4'd0;
  assign i_tag = (cpl_own == OWN_I) ? mem2proc_tag : 4'd0;
  assign p_tag = (cpl_own == OWN_P) ? mem2proc_tag : 4'd0;

  // Accept write follows the completion clear so a same-tag reuse keeps the new owner.
  always_comb begin
    owner_d = owner_q;
    if (cpl && tag_ok) owner_d[int'(mem2proc_tag)] = OWN_NONE;
    if (rsp_ok) owner_d[int'(mem2proc_response)] = gnt;
  end

  always_comb begin
    starve_d = '0;
    if (i_act && gnt != OWN_I)
      starve_d = (starve_q == SLIM) ? starve_q : starve_q + 1'b1;
  end

  assign tag_err_d = tag_err_q | (cpl && cpl_own == OWN_NONE);
  assign tag_err   = tag_err_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_q  <= '0;
      tag_err_q <= 1'b0;
      for (int k = 0; k <= NUM_TAGS; k++) owner_q[k] <= OWN_NONE;
    end else begin
      starve_q  <= starve_d;
      tag_err_q <= tag_err_d;
      for (int k = 0; k <= NUM_TAGS; k++) owner_q[k] <= owner_d[k];
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] pd_q, pi_q, pp_q, pr_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pd_q <= '0;
      pi_q <= '0;
      pp_q <= '0;
      pr_q <= '0;
    end else begin
      if (acc && gnt == OWN_D) pd_q <= pd_q + 32'd1;
      if (acc && gnt == OWN_I) pi_q <= pi_q + 32'd1;
      if (acc && gnt == OWN_P) pp_q <= pp_q + 32'd1;
      if (gnt != OWN_NONE && !acc) pr_q <= pr_q + 32'd1;
    end
  end

  assign perf_d_grants = pd_q;
  assign perf_i_grants = pi_q;
  assign perf_p_grants = pp_q;
  assign perf_rejects  = pr_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized bench for mem_bus_arbiter.
// Checks every output against a tag-table / starvation reference model.
module tb_mem_bus_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  d_command, i_command, p_command;
  logic [31:0] d_addr, i_addr, p_addr;
  logic [63:0] d_data, mem2proc_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data, mem_data;
  logic [3:0]  d_response, i_response, p_response;
  logic [3:0]  d_tag, i_tag, p_tag;
  logic        give_way, tag_err;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_d_grants, perf_i_grants, perf_p_grants, perf_rejects;
`endif

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .d_command(d_command), .d_addr(d_addr), .d_data(d_data),
    .i_command(i_command), .i_addr(i_addr),
    .p_command(p_command), .p_addr(p_addr),
    .mem2proc_response(mem2proc_response),
    .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data),
    .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .d_response(d_response), .i_response(i_response),
    .p_response(p_response),
    .d_tag(d_tag), .i_tag(i_tag), .p_tag(p_tag),
    .mem_data(mem_data), .give_way(give_way), .tag_err(tag_err)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_d_grants(perf_d_grants), .perf_i_grants(perf_i_grants),
    .perf_p_grants(perf_p_grants), .perf_rejects(perf_rejects)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model: 0 none, 1 dcache, 2 icache, 3 prefetch.
  int owner [16];
  int starve;
  bit err;

  logic [1:0]  o_cmd;
  logic [31:0] o_addr;
  logic [3:0]  o_dr, o_ir, o_pr, o_dt, o_it, o_pt;
  logic        o_gw, o_err;

  task automatic chk(input string nm, input logic [63:0] o,
                     input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, o, e);
    end
  endtask

  task automatic step(input logic [1:0] dc, input logic [31:0] da,
                      input logic [63:0] dd, input logic [1:0] ic,
                      input logic [31:0] ia, input logic [1:0] pc,
                      input logic [31:0] pa, input logic [3:0] rsp,
                      input logic [3:0] tg, input logic [63:0] md,
                      input bit rn);
    int g, ot;
    logic [1:0]  ecmd;
    logic [31:0] eaddr;
    logic [63:0] edata;
    d_command = dc; d_addr = da; d_data = dd;
    i_command = ic; i_addr = ia;
    p_command = pc; p_addr = pa;
    mem2proc_response = rsp; mem2proc_tag = tg;
    mem2proc_data = md; reset = rn;
    #3;
    g = 0;
    if (ic != 0 && starve == 8) g = 2;
    else if (dc != 0) g = 1;
    else if (ic != 0) g = 2;
    else if (pc != 0) g = 3;
    ecmd = 2'd0; eaddr = 32'd0; edata = 64'd0;
    if (g == 1) begin ecmd = dc; eaddr = da; edata = dd; end
    if (g == 2) begin ecmd = ic; eaddr = ia; end
    if (g == 3) begin ecmd = pc; eaddr = pa; end
    ot = (tg != 0) ? owner[tg] : 0;
    chk("cmd", 64'(proc2mem_command), 64'(ecmd));
    chk("addr", 64'(proc2mem_addr), 64'(eaddr));
    chk("wdata", proc2mem_data, edata);
    chk("d_rsp", 64'(d_response), (g == 1) ? 64'(rsp) : 64'd0);
    chk("i_rsp", 64'(i_response), (g == 2) ? 64'(rsp) : 64'd0);
    chk("p_rsp", 64'(p_response), (g == 3) ? 64'(rsp) : 64'd0);
    chk("d_tag", 64'(d_tag), (ot == 1) ? 64'(tg) : 64'd0);
    chk("i_tag", 64'(i_tag), (ot == 2) ? 64'(tg) : 64'd0);
    chk("p_tag", 64'(p_tag), (ot == 3) ? 64'(tg) : 64'd0);
    chk("mem_data", mem_data, md);
    chk("give_way", 64'(give_way), 64'(pc != 0 && g != 3));
    chk("tag_err", 64'(tag_err), 64'(err));
    o_cmd = proc2mem_command; o_addr = proc2mem_addr;
    o_dr = d_response; o_ir = i_response; o_pr = p_response;
    o_dt = d_tag; o_it = i_tag; o_pt = p_tag;
    o_gw = give_way; o_err = tag_err;
    @(posedge clock);
    if (!rn) begin
      for (int k = 0; k < 16; k++) owner[k] = 0;
      starve = 0;
      err = 0;
    end else begin
      if (ic != 0 && g != 2) starve = (starve < 8) ? starve + 1 : 8;
      else starve = 0;
      if (tg != 0) begin
        if (ot == 0) err = 1;
        owner[tg] = 0;
      end
      if (g != 0 && rsp != 0) owner[rsp] = g;
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] tg, input bit rn);
    step(2'd0, 32'd0, 64'd0, 2'd0, 32'd0, 2'd0, 32'd0,
         4'd0, tg, 64'd0, rn);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) owner[k] = 0;
    starve = 0;
    err = 0;
    reset = 1'b0;
    d_command = 0; i_command = 0; p_command = 0;
    d_addr = 0; i_addr = 0; p_addr = 0; d_data = 0;
    mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
    @(posedge clock);
    #1;
    idle(4'd0, 1'b0);
    idle(4'd0, 1'b1);
    chk("rst_cmd", 64'(o_cmd), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);

    // Priority
    step(2'd1, 32'h1000, 64'hdead, 2'd1, 32'h2000, 2'd1, 32'h3000,
         4'd3, 4'd0, 64'd0, 1'b1);
    chk("t1_addr", 64'(o_addr), 64'h1000);
    chk("t1_drsp", 64'(o_dr), 64'd3);
    chk("t1_irsp", 64'(o_ir), 64'd0);
    chk("t1_prsp", 64'(o_pr), 64'd0);
    chk("t1_gw", 64'(o_gw), 64'd1);
    idle(4'd3, 1'b1);

    // Routing
    step(2'd0, 0, 0, 2'd0, 0, 2'd1, 32'h3040, 4'd5, 4'd0, 0, 1'b1);
    step(2'd0, 0, 0, 2'd1, 32'h2040, 2'd0, 0, 4'd7, 4'd0, 0, 1'b1);
    idle(4'd7, 1'b1);
    chk("t2_itag", 64'(o_it), 64'd7);
    chk("t2_ptag0", 64'(o_pt), 64'd0);
    idle(4'd5, 1'b1);
    chk("t2_ptag", 64'(o_pt), 64'd5);
    chk("t2_itag0", 64'(o_it), 64'd0);

    // Starvation
    for (int c = 1; c <= 10; c++) begin
      step(2'd1, 32'h1000, 64'h1, 2'd1, 32'h2000, 2'd0, 0,
           4'd0, 4'd0, 0, 1'b1);
      chk("t3_addr", 64'(o_addr), (c == 9) ? 64'h2000 : 64'h1000);
    end
    idle(4'd0, 1'b1);

    // Reject
    step(2'd0, 0, 0, 2'd0, 0, 2'd1, 32'h3080, 4'd0, 4'd0, 0, 1'b1);
    chk("t4_prsp", 64'(o_pr), 64'd0);
    chk("t4_gw", 64'(o_gw), 64'd0);
    chk("t4_cmd", 64'(o_cmd), 64'd1);
    idle(4'd0, 1'b1);

    // Same-tag collision
    step(2'd2, 32'h1100, 64'h55, 2'd0, 0, 2'd0, 0, 4'd4, 4'd0, 0, 1'b1);
    step(2'd0, 0, 0, 2'd1, 32'h2100, 2'd0, 0, 4'd4, 4'd4, 0, 1'b1);
    chk("t5_dtag", 64'(o_dt), 64'd4);
    chk("t5_itag0", 64'(o_it), 64'd0);
    idle(4'd4, 1'b1);
    chk("t5_itag", 64'(o_it), 64'd4);

    // Unowned tag, then reset with a tag outstanding
    idle(4'd9, 1'b1);
    chk("t6_none", 64'({o_dt, o_it, o_pt}), 64'd0);
    chk("t6_err0", 64'(o_err), 64'd0);
    step(2'd1, 32'h1200, 0, 2'd0, 0, 2'd0, 0, 4'd11, 4'd0, 0, 1'b1);
    chk("t6_err1", 64'(o_err), 64'd1);
    idle(4'd0, 1'b0);
    idle(4'd0, 1'b1);
    chk("t6_errclr", 64'(o_err), 64'd0);
    idle(4'd11, 1'b1);
    chk("t6_dtag0", 64'(o_dt), 64'd0);
    idle(4'd0, 1'b1);
    chk("t6_err2", 64'(o_err), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      logic [3:0] r, t;
      r = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      t = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step(2'($urandom_range(0, 2)), $urandom, {$urandom, $urandom},
           2'($urandom_range(0, 1)), $urandom,
           2'($urandom_range(0, 1)), $urandom,
           r, t, {$urandom, $urandom}, ($urandom_range(0, 39) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
